// File: rtl/processing_element_mc.sv
// rtl/processing_element_mc.sv - multi-lane input-stationary systolic PE with scan-drained accumulators
// Optional feature: define PE_ZERO_GATING_EN for threshold zero gating and the gated_cnt counter.
module processing_element_mc #(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_MAC = 48,
  parameter int WIDTH_T   = 2,
  parameter int LANES     = 4,
  parameter int STAGE     = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LANES*WIDTH_A-1:0]     a_in,
  input  logic                         load_en,
  input  logic                         c_switch,
  input  logic [LANES*WIDTH_B-1:0]     b_in,
  input  logic [LANES*WIDTH_MAC-1:0]   mac_in,
  input  logic                         pipeline_en,
  input  logic                         cell_en,
  input  logic                         reg_clear,
  input  logic                         mode,
  input  logic                         cscan_en,
  input  logic [WIDTH_MAC-1:0]         scan_in,
  input  logic [WIDTH_T-1:0]           thres,
  input  logic                         cell_sc_en,
  output logic                         cell_out,
  output logic [WIDTH_MAC-1:0]         scan_out,
  output logic [LANES*WIDTH_B-1:0]     weight_out,
  output logic [LANES*WIDTH_MAC-1:0]   mac_out
);

  localparam int PW = WIDTH_A + WIDTH_B;

  logic adv;
  logic do_comp;
  assign adv     = pipeline_en & cell_en;
  assign do_comp = adv & ~cscan_en & ~reg_clear;

  logic [WIDTH_A-1:0]   shadow [LANES];
  logic [WIDTH_A-1:0]   active [LANES];
  logic [WIDTH_MAC-1:0] acc    [LANES];
  logic [WIDTH_MAC-1:0] mac_q  [LANES];
  logic [WIDTH_B-1:0]   w_q    [LANES];
  logic                 cell_q;

  logic [LANES*WIDTH_MAC-1:0] prod_x;
  logic [WIDTH_MAC-1:0]       prod_use [LANES];
  logic [WIDTH_MAC-1:0]       mac_use  [LANES];

`ifdef PE_ZERO_GATING_EN
  logic [LANES-1:0] gate;
`else
  logic unused_thres;
  assign unused_thres = ^thres;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [WIDTH_A-1:0] a_s;
    logic signed [WIDTH_B-1:0] b_s;
    logic signed [PW-1:0]      p;
    assign a_s = active[i];
    assign b_s = b_in[i*WIDTH_B +: WIDTH_B];
    assign p   = PW'(a_s) * PW'(b_s);
`ifdef PE_ZERO_GATING_EN
    // One extra magnitude bit so the most negative operand is not mistaken for small.
    logic [WIDTH_A:0] a_ext, a_mag, a_lim;
    logic [WIDTH_B:0] b_ext, b_mag, b_lim;
    assign a_ext = {a_s[WIDTH_A-1], a_s};
    assign b_ext = {b_s[WIDTH_B-1], b_s};
    assign a_mag = a_ext[WIDTH_A] ? -a_ext : a_ext;
    assign b_mag = b_ext[WIDTH_B] ? -b_ext : b_ext;
    assign a_lim = (WIDTH_A+1)'(1) << thres;
    assign b_lim = (WIDTH_B+1)'(1) << thres;
    assign gate[i] = (a_mag < a_lim) || (b_mag < b_lim);
    assign prod_x[i*WIDTH_MAC +: WIDTH_MAC] = gate[i] ? '0 : WIDTH_MAC'(p);
`else
    assign prod_x[i*WIDTH_MAC +: WIDTH_MAC] = WIDTH_MAC'(p);
`endif
    assign weight_out[i*WIDTH_B +: WIDTH_B]   = w_q[i];
    assign mac_out[i*WIDTH_MAC +: WIDTH_MAC]  = mac_q[i];
  end

  if (STAGE == 1) begin : g_pipe
    // mac_in is delayed alongside the product so both reach the adder together.
    logic [WIDTH_MAC-1:0] prod_q [LANES];
    logic [WIDTH_MAC-1:0] mac_d  [LANES];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LANES; i++) begin
          prod_q[i] <= '0;
          mac_d[i]  <= '0;
        end
      end else if (reg_clear) begin
        for (int i = 0; i < LANES; i++) begin
          prod_q[i] <= '0;
          mac_d[i]  <= '0;
        end
      end else if (do_comp) begin
        for (int i = 0; i < LANES; i++) begin
          prod_q[i] <= prod_x[i*WIDTH_MAC +: WIDTH_MAC];
          mac_d[i]  <= mac_in[i*WIDTH_MAC +: WIDTH_MAC];
        end
      end
    end
    always_comb begin
      for (int i = 0; i < LANES; i++) begin
        prod_use[i] = prod_q[i];
        mac_use[i]  = mac_d[i];
      end
    end
  end else begin : g_comb
    always_comb begin
      for (int i = 0; i < LANES; i++) begin
        prod_use[i] = prod_x[i*WIDTH_MAC +: WIDTH_MAC];
        mac_use[i]  = mac_in[i*WIDTH_MAC +: WIDTH_MAC];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
        acc[i]    <= '0;
        mac_q[i]  <= '0;
        w_q[i]    <= '0;
      end
      cell_q <= 1'b0;
    end else begin
      // Stationary registers survive reg_clear; a simultaneous load lands after the switch reads shadow.
      for (int i = 0; i < LANES; i++) begin
        if (load_en) shadow[i] <= a_in[i*WIDTH_A +: WIDTH_A];
        if (adv && c_switch) active[i] <= shadow[i];
      end
      cell_q <= reg_clear ? 1'b0 : cell_sc_en;
      if (reg_clear) begin
        for (int i = 0; i < LANES; i++) begin
          acc[i]   <= '0;
          mac_q[i] <= '0;
          w_q[i]   <= '0;
        end
      end else if (cscan_en) begin
        acc[0] <= scan_in;
        for (int i = 1; i < LANES; i++) acc[i] <= acc[i-1];
      end else if (adv) begin
        for (int i = 0; i < LANES; i++) begin
          w_q[i] <= b_in[i*WIDTH_B +: WIDTH_B];
          if (mode) begin
            acc[i]   <= acc[i] + prod_use[i];
            mac_q[i] <= mac_use[i];
          end else begin
            mac_q[i] <= mac_use[i] + prod_use[i];
          end
        end
      end
    end
  end

`ifdef PE_ZERO_GATING_EN
  logic [15:0] gated_cnt;
  logic [16:0] cnt_sum;
  always_comb begin
    cnt_sum = {1'b0, gated_cnt};
    for (int i = 0; i < LANES; i++) cnt_sum = cnt_sum + 17'(gate[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gated_cnt <= '0;
    end else if (reg_clear) begin
      gated_cnt <= '0;
    end else if (do_comp) begin
      gated_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
`endif

  assign scan_out = acc[LANES-1];
  assign cell_out = cell_q;

endmodule

// File: tb/tb_processing_element_mc.sv
// tb/tb_processing_element_mc.sv - directed self-checking bench for processing_element_mc (default parameters)
module tb_processing_element_mc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  a_in;
  logic         load_en;
  logic         c_switch;
  logic [63:0]  b_in;
  logic [191:0] mac_in;
  logic         pipeline_en;
  logic         cell_en;
  logic         reg_clear;
  logic         mode;
  logic         cscan_en;
  logic [47:0]  scan_in;
  logic [1:0]   thres;
  logic         cell_sc_en;
  logic         cell_out;
  logic [47:0]  scan_out;
  logic [63:0]  weight_out;
  logic [191:0] mac_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  processing_element_mc dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .load_en(load_en), .c_switch(c_switch),
    .b_in(b_in), .mac_in(mac_in), .pipeline_en(pipeline_en), .cell_en(cell_en),
    .reg_clear(reg_clear), .mode(mode), .cscan_en(cscan_en), .scan_in(scan_in),
    .thres(thres), .cell_sc_en(cell_sc_en), .cell_out(cell_out), .scan_out(scan_out),
    .weight_out(weight_out), .mac_out(mac_out)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] sx(input int v);
    return 48'(v);
  endfunction

  function automatic logic [191:0] pk(input int v0, input int v1, input int v2, input int v3);
    return {sx(v3), sx(v2), sx(v1), sx(v0)};
  endfunction

  function automatic logic [63:0] pkw(input int w0, input int w1, input int w2, input int w3);
    return {16'(w3), 16'(w2), 16'(w1), 16'(w0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; a_in = '0; load_en = 0; c_switch = 0; b_in = '0; mac_in = '0;
    pipeline_en = 0; cell_en = 1; reg_clear = 0; mode = 0; cscan_en = 0;
    scan_in = '0; thres = 2'd0; cell_sc_en = 0;
    tick(); tick();
    check("rst_mac_out", mac_out, '0);
    check("rst_weight_out", weight_out, '0);
    check("rst_scan_out", scan_out, '0);
    check("rst_cell_out", cell_out, '0);
    rst_n = 1'b1;

    // Basic systolic MAC: shadow=3, switch, 3*5+10
    a_in = pkw(3, 3, 3, 3); load_en = 1; tick();
    load_en = 0; c_switch = 1; pipeline_en = 1; cell_sc_en = 1;
    b_in = pkw(5, 5, 5, 5); mac_in = pk(10, 10, 10, 10); tick();
    check("switch_edge_old_active", mac_out, pk(10, 10, 10, 10));
    check("cell_out_follow", cell_out, 1'b1);
    c_switch = 0; tick();
    check("mac_basic", mac_out, pk(25, 25, 25, 25));
    check("weight_basic", weight_out, pkw(5, 5, 5, 5));

    // Local accumulation then scan drain
    pipeline_en = 0; load_en = 1; a_in = pkw(5, 1, 3, -2); tick();
    load_en = 0; c_switch = 1; pipeline_en = 1; b_in = '0; mac_in = '0; tick();
    c_switch = 0; mode = 1; b_in = pkw(7, 7, 7, 7); mac_in = pk(10, 10, 10, 10);
    repeat (4) tick();
    check("acc_passthrough", mac_out, pk(10, 10, 10, 10));
    check("acc_lane3", scan_out, sx(-56));
    cscan_en = 1; scan_in = '0; b_in = pkw(1, 1, 1, 1);
    tick(); check("scan_lane2", scan_out, sx(84));
    tick(); check("scan_lane1", scan_out, sx(28));
    tick(); check("scan_lane0", scan_out, sx(140));
    tick(); check("scan_tail", scan_out, sx(0));
    check("scan_hold_weight", weight_out, pkw(7, 7, 7, 7));
    check("scan_hold_mac", mac_out, pk(10, 10, 10, 10));
    cscan_en = 0;

    // Streaming with a 3-cycle stall in the middle
    mode = 0; mac_in = '0;
    for (int bv = 1; bv <= 6; bv++) begin
      b_in = pkw(bv, bv, bv, bv); pipeline_en = 1; tick();
      check($sformatf("stream_b%0d", bv), mac_out, pk(5*bv, bv, 3*bv, -2*bv));
      if (bv == 3) begin
        pipeline_en = 0; b_in = pkw(100, 100, 100, 100); mac_in = pk(7, 7, 7, 7);
        for (int s = 0; s < 3; s++) begin
          tick();
          check($sformatf("stall_mac_%0d", s), mac_out, pk(15, 3, 9, -6));
          check($sformatf("stall_w_%0d", s), weight_out, pkw(3, 3, 3, 3));
        end
        mac_in = '0;
      end
    end

    // Simultaneous load and switch
    pipeline_en = 0; load_en = 1; a_in = pkw(4, 4, 4, 4); tick();
    pipeline_en = 1; a_in = pkw(9, 9, 9, 9); c_switch = 1; b_in = pkw(2, 2, 2, 2); tick();
    check("ldsw_old_active", mac_out, pk(10, 2, 6, -4));
    load_en = 0; c_switch = 0; tick();
    check("ldsw_uses_old_shadow", mac_out, pk(8, 8, 8, 8));
    c_switch = 1; tick();
    check("ldsw_second_switch_edge", mac_out, pk(8, 8, 8, 8));
    c_switch = 0; tick();
    check("ldsw_new_applied", mac_out, pk(18, 18, 18, 18));

    // reg_clear beats scan and adv; stationary registers survive
    mode = 1; b_in = pkw(1, 1, 1, 1); mac_in = pk(3, 3, 3, 3);
    load_en = 1; a_in = pkw(6, 6, 6, 6); cell_sc_en = 1; tick();
    load_en = 0;
    check("pre_clear_acc", scan_out, sx(9));
    check("pre_clear_mac", mac_out, pk(3, 3, 3, 3));
    reg_clear = 1; cscan_en = 1; scan_in = sx(77); tick();
    check("clr_mac_out", mac_out, '0);
    check("clr_weight_out", weight_out, '0);
    check("clr_scan_out", scan_out, '0);
    check("clr_cell_out", cell_out, 1'b0);
    reg_clear = 0; cscan_en = 0; mode = 0; mac_in = '0; c_switch = 1; tick();
    check("clr_active_kept", mac_out, pk(9, 9, 9, 9));
    c_switch = 0; tick();
    check("clr_shadow_kept", mac_out, pk(6, 6, 6, 6));
    check("clr_acc_held_mode0", scan_out, sx(0));

`ifdef PE_ZERO_GATING_EN
    thres = 2'd2; mac_in = pk(10, 10, 10, 10); b_in = pkw(3, 8, 8, 8); tick();
    check("zg_gated", mac_out, pk(10, 58, 58, 58));
    check("zg_count1", dut.gated_cnt, 16'd1);
    b_in = pkw(-4, 8, 8, 8); tick();
    check("zg_full", mac_out, pk(-14, 58, 58, 58));
    check("zg_count_hold", dut.gated_cnt, 16'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
